// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_det_pkg;

    typedef enum logic {
        ST_UNCFG = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Bits needed to hold a length value in 0..max_len.
    function automatic int unsigned calc_len_w(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_det_core.sv
// Shift history, fill tracking and pattern compare; hit_c flags a match on the bit being accepted.
module seq_det_core
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = calc_len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               accept,
    input  logic               in_bit,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               hit_c
);

    localparam int unsigned LW1 = LEN_W + 1;

    logic [MAX_LEN-1:0] history_q, history_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] new_hist;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_inc;
    logic               enough;

    always_comb begin
        history_d = history_q;
        fill_d    = fill_q;
        new_hist  = {history_q[MAX_LEN-2:0], in_bit};
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            mask[i] = (32'(i) < 32'(len));
        end
        fill_inc = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
        // Count includes the bit arriving this cycle.
        enough   = ((LW1'(fill_q) + LW1'(1)) >= LW1'(len));
        hit_c    = accept && enough && (((new_hist ^ pattern) & mask) == '0);

        if (clear) begin
            history_d = '0;
            fill_d    = '0;
        end else if (accept) begin
            history_d = new_hist;
            fill_d    = (hit_c && !overlap) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            history_q <= '0;
            fill_q    <= '0;
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with match pulse and saturating match counter.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned LEN_W   = calc_len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               armed,
    output logic               cfg_err,
    output logic               match,
    output logic [CNT_W-1:0]   match_count
);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic               armed_q, armed_d;
    logic               cfg_err_q, cfg_err_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               legal_c;
    logic               accept_c;
    logic               hit_c;

    seq_det_core #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .clear   (legal_c),
        .accept  (accept_c),
        .in_bit  (in_bit),
        .pattern (pattern_q),
        .len     (len_q),
        .overlap (overlap_q),
        .hit_c   (hit_c)
    );

    // A load of any kind wins over a concurrent bit.
    always_comb begin
        legal_c  = cfg_load && (cfg_len != '0) && (32'(cfg_len) <= MAX_LEN);
        accept_c = (state_q == ST_RUN) && in_valid && !cfg_load;
    end

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        cnt_d     = cnt_q;
        cfg_err_d = cfg_load && !legal_c;
        match_d   = hit_c;

        if (legal_c) begin
            state_d   = ST_RUN;
            pattern_d = cfg_pattern;
            len_d     = cfg_len;
            overlap_d = cfg_overlap;
            cnt_d     = '0;
        end else if (hit_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        armed_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_UNCFG;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            armed_q   <= 1'b0;
            cfg_err_q <= 1'b0;
            match_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            armed_q   <= armed_d;
            cfg_err_q <= cfg_err_d;
            match_q   <= match_d;
            cnt_q     <= cnt_d;
        end
    end

    assign armed       = armed_q;
    assign cfg_err     = cfg_err_q;
    assign match       = match_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench: per-cycle expectations from a bit-window model, popped and compared by a monitor.
module tb_seq_detector_prog;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_bit = 1'b0;
    logic               armed;
    logic               cfg_err;
    logic               match;
    logic [CNT_W-1:0]   match_count;

    seq_detector_prog #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .armed       (armed),
        .cfg_err     (cfg_err),
        .match       (match),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit m;
        bit a;
        bit e;
        int c;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: accepted bits since the last load (or last match in non-overlap mode).
    bit   m_run = 0;
    bit   m_ovl = 0;
    int   m_len = 0;
    bit [MAX_LEN-1:0] m_pat = '0;
    bit   win[$];
    int   m_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit window_matches();
        if (win.size() < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            if (win[win.size() - 1 - i] != m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic cyc(input bit r, input bit ld, input bit [MAX_LEN-1:0] pat,
                       input bit [LEN_W-1:0] len, input bit ovl, input bit v, input bit b);
        exp_t e;
        bit   hit;
        rst = r; cfg_load = ld; cfg_pattern = pat; cfg_len = len;
        cfg_overlap = ovl; in_valid = v; in_bit = b;
        hit = 1'b0;
        if (r) begin
            m_run = 0; win.delete(); m_cnt = 0;
            e = '{m: 0, a: 0, e: 0, c: 0};
        end else if (ld) begin
            if (len >= 1 && int'(len) <= int'(MAX_LEN)) begin
                m_run = 1; m_pat = pat; m_len = int'(len); m_ovl = ovl;
                win.delete(); m_cnt = 0;
                e = '{m: 0, a: 1, e: 0, c: 0};
            end else begin
                e = '{m: 0, a: m_run, e: 1, c: m_cnt};
            end
        end else begin
            if (m_run && v) begin
                win.push_back(b);
                if (win.size() > int'(MAX_LEN)) void'(win.pop_front());
                hit = window_matches();
                if (hit) begin
                    if (m_cnt < CNT_MAX) m_cnt++;
                    if (!m_ovl) win.delete();
                end
            end
            e = '{m: hit, a: m_run, e: 0, c: m_cnt};
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(0, 0, MAX_LEN'($urandom), LEN_W'($urandom), 1'($urandom), 0, 1'($urandom));
    endtask

    task automatic send(input bit b);
        cyc(0, 0, MAX_LEN'($urandom), LEN_W'($urandom), 1'($urandom), 1, b);
    endtask

    task automatic load(input bit [MAX_LEN-1:0] pat, input bit [LEN_W-1:0] len, input bit ovl);
        cyc(0, 1, pat, len, ovl, 0, 0);
    endtask

    task automatic send_1011011();
        bit [6:0] s;
        s = 7'b1011011;
        for (int i = 6; i >= 0; i--) send(s[i]);
    endtask

    // Monitor: compares DUT outputs after every edge against the queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("sb_match", int'(match), int'(e.m));
            chk("sb_armed", int'(armed), int'(e.a));
            chk("sb_cfg_err", int'(cfg_err), int'(e.e));
            chk("sb_count", int'(match_count), e.c);
        end
    end

    initial begin
        bit [6:0] s;
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 1);
        chk("reset_armed", int'(armed), 0);
        chk("reset_count", int'(match_count), 0);
        send(1);
        chk("uncfg_no_match", int'(match), 0);

        load(8'h0B, 4, 1);
        send_1011011();
        chk("t1_overlap_count", int'(match_count), 2);
        idle(1);

        load(8'h0B, 4, 0);
        send_1011011();
        chk("t2_nonoverlap_count", int'(match_count), 1);

        load(8'h03, 2, 1);
        repeat (4) send(1);
        chk("t3_overlap_11", int'(match_count), 3);
        load(8'h03, 2, 0);
        repeat (4) send(1);
        chk("t3_nonoverlap_11", int'(match_count), 2);

        load(8'h0B, 4, 1);
        s = 7'b1011011;
        for (int i = 6; i >= 0; i--) begin
            send(s[i]);
            idle($urandom_range(0, 5));
        end
        chk("t4_gaps_count", int'(match_count), 2);

        cyc(0, 1, 8'hFF, 0, 0, 0, 0);
        chk("t5_len0_err", int'(cfg_err), 1);
        chk("t5_len0_armed", int'(armed), 1);
        chk("t5_len0_count", int'(match_count), 2);
        cyc(0, 1, 8'hFF, LEN_W'(MAX_LEN + 1), 0, 0, 0);
        chk("t5_len9_err", int'(cfg_err), 1);
        chk("t5_len9_count", int'(match_count), 2);
        cyc(0, 1, 8'h0B, 4, 1, 1, 1);
        send(0); send(1); send(1);
        chk("t5_dropped_bit", int'(match_count), 0);

        load(8'h01, 1, 0);
        repeat (20) send(1);
        chk("t6_saturate", int'(match_count), CNT_MAX);
        send(0);
        chk("t6_len1_zero", int'(match), 0);

        load(8'h0B, 4, 1);
        send(1); send(0); send(1);
        cyc(1, 0, 0, 0, 0, 1, 1);
        chk("t6_rst_match", int'(match), 0);
        chk("t6_rst_armed", int'(armed), 0);
        chk("t6_rst_count", int'(match_count), 0);
        send(1); send(0); send(1); send(1);
        chk("t6_uncfg_ignored", int'(match_count), 0);
        cyc(0, 1, 8'h0B, 0, 1, 0, 0);
        chk("t6_uncfg_bad_armed", int'(armed), 0);

        for (int seg = 0; seg < 200; seg++) begin
            int unsigned len;
            if ($urandom_range(0, 99) < 5) cyc(1, 0, 0, 0, 0, 1'($urandom), 1'($urandom));
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, MAX_LEN);
            cyc(0, 1, MAX_LEN'($urandom), LEN_W'(len), 1'($urandom), 1'($urandom), 1'($urandom));
            for (int k = 0; k < int'($urandom_range(5, 60)); k++) begin
                if ($urandom_range(0, 99) == 0)
                    cyc(0, 1, MAX_LEN'($urandom), LEN_W'($urandom_range(1, MAX_LEN)),
                        1'($urandom), 1'($urandom), 1'($urandom));
                else
                    cyc(0, 0, MAX_LEN'($urandom), LEN_W'($urandom), 1'($urandom),
                        $urandom_range(0, 3) != 0, 1'($urandom));
            end
        end

        idle(2);
        for (int w = 0; w < 5 && sbq.size() > 0; w++) @(posedge clk);
        #3;
        chk("sb_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
